// File: rtl/adc_scan_scheduler_if.sv
// ADC wrapper and result-side signals of the scan scheduler.
// master = scheduler, slave = ADC wrapper / result consumer.
interface adc_scan_scheduler_if;
    logic [4:0]  adc_ch;
    logic        sync_tr;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        res_valid;
    logic [3:0]  res_ch;
    logic [11:0] res_data;
    logic        scan_done;

    modport master (
        output adc_ch, sync_tr, res_valid, res_ch, res_data, scan_done,
        input  adc_data, adc_valid
    );

    modport slave (
        input  adc_ch, sync_tr, res_valid, res_ch, res_data, scan_done,
        output adc_data, adc_valid
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Round-robin conversion sequencer for the MAX10 ADC wrapper. Walks the set
// bits of a mask latched at scan start, pulses sync_tr once per channel, waits
// for the rising edge of adc_valid (or a timeout) and emits tagged results.
module adc_scan_scheduler #(
    parameter int NUM_CH      = 8,
    parameter int CH_BASE     = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SCAN_PERIOD = 0
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              err_clr,
    output logic              busy,
    output logic              timeout_err,
    adc_scan_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, ISSUE, WAIT, STORE, DONE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = $clog2(SCAN_PERIOD + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PER_MAX  = PW'(SCAN_PERIOD);
    localparam logic [PW-1:0] PER_LAST = (SCAN_PERIOD > 0) ? PW'(SCAN_PERIOD - 1) : '0;

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [3:0]        idx;
    logic [TW-1:0]     tmo_cnt;
    logic [PW-1:0]     per_cnt;
    logic              valid_q;
    logic              adc_edge;
    logic              per_expired;
    logic [4:0]        first_hit;
    logic [4:0]        next_hit;

    // {found, index} of the lowest set bit of m at or above position 'from'
    function automatic logic [4:0] find_from(input logic [NUM_CH-1:0] m, input logic [4:0] from);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (5'(i) >= from && m[i]) r = {1'b1, 4'(i)};
        return r;
    endfunction

    assign adc_edge  = bus.adc_valid & ~valid_q;
    assign first_hit = find_from(ch_mask, 5'd0);
    assign next_hit  = find_from(mask_q, {1'b0, idx} + 5'd1);
    // per_cnt equals cycles elapsed since START, so a decision at PERIOD-1
    // puts the next START exactly SCAN_PERIOD cycles after the previous one
    assign per_expired = (SCAN_PERIOD == 0) || (per_cnt >= PER_LAST);

    // Scan period counter: restarts on START, saturates at SCAN_PERIOD
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)
            per_cnt <= '0;
        else if (SCAN_PERIOD == 0)
            per_cnt <= '0;
        else if (state == START)
            per_cnt <= PW'(1);
        else if (per_cnt < PER_MAX)
            per_cnt <= per_cnt + 1'b1;
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mask_q        <= '0;
            idx           <= '0;
            tmo_cnt       <= '0;
            valid_q       <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            bus.adc_ch    <= 5'(CH_BASE);
            bus.sync_tr   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_data  <= '0;
            bus.scan_done <= 1'b0;
        end else begin
            valid_q       <= bus.adc_valid;
            bus.sync_tr   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.scan_done <= 1'b0;
            // a timeout set later in this block overrides the clear
            if (err_clr) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (en && per_expired && ch_mask != '0) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    mask_q <= ch_mask;
                    if (first_hit[4]) begin
                        idx         <= first_hit[3:0];
                        bus.adc_ch  <= 5'(CH_BASE) + {1'b0, first_hit[3:0]};
                        tmo_cnt     <= '0;
                        bus.sync_tr <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // the sync_tr cycle counts toward the timeout
                    tmo_cnt <= tmo_cnt + 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (adc_edge) begin
                        bus.res_valid <= 1'b1;
                        bus.res_ch    <= idx;
                        bus.res_data  <= bus.adc_data;
                        state         <= STORE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= STORE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                STORE: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (next_hit[4]) begin
                        idx         <= next_hit[3:0];
                        bus.adc_ch  <= 5'(CH_BASE) + {1'b0, next_hit[3:0]};
                        tmo_cnt     <= '0;
                        bus.sync_tr <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        bus.scan_done <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (en && per_expired) begin
                        state <= START;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler. A responder process plays the ADC
// wrapper and pushes expected results; the same negedge process pops and
// compares whenever res_valid is seen. Channel order comes from a mask-level
// model (next set bit, new scan samples the current mask).
module tb_adc_scan_scheduler;
    logic       sys_clk = 1'b0;
    logic       reset_n, en, err_clr;
    logic [7:0] ch_mask;
    logic       busy, timeout_err;
    logic       reset_b_n, en_b, err_clr_b;
    logic [7:0] mask_b;
    logic       busy_b, terr_b;

    always #5 sys_clk = ~sys_clk;

    adc_scan_scheduler_if ifa();
    adc_scan_scheduler_if ifb();

    adc_scan_scheduler #(.NUM_CH(8), .CH_BASE(1), .TIMEOUT_CYC(1024), .SCAN_PERIOD(0)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .en(en), .ch_mask(ch_mask), .err_clr(err_clr),
        .busy(busy), .timeout_err(timeout_err), .bus(ifa.master));

    adc_scan_scheduler #(.NUM_CH(8), .CH_BASE(1), .TIMEOUT_CYC(1024), .SCAN_PERIOD(500)) dut_per (
        .sys_clk(sys_clk), .reset_n(reset_b_n), .en(en_b), .ch_mask(mask_b), .err_clr(err_clr_b),
        .busy(busy_b), .timeout_err(terr_b), .bus(ifb.master));

    typedef struct {int ch; int data;} res_t;
    res_t sbq[$];

    int checks = 0, errors = 0, cyc = 0;
    int n_sync = 0, n_done = 0, n_res = 0;
    int exp_done_iss = 0, done_adj = 0, en_drops = 0;
    int last_idx = 0, lat = 20, silent_sync_cyc = -1;
    logic [7:0] scan_mask = '0;
    bit silent2 = 0, rand_data = 0, b_done = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int next_bit(input logic [7:0] m, input int from);
        for (int i = from; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic run(input int n);
        repeat (n) begin @(negedge sys_clk); #1; end
    endtask

    // idx < 0 waits for any sync_tr
    task automatic wait_sync(input int idx, input int bound, input string name);
        bit ok = 0;
        int n0;
        for (int i = 0; i < bound && !ok; i++) begin
            n0 = n_sync;
            run(1);
            if (n_sync != n0 && (idx < 0 || last_idx == idx)) ok = 1;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_done_cnt(input int target, input int bound, input string name);
        for (int i = 0; i < bound && n_done < target; i++) run(1);
        chk(name, n_done, target);
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound && busy; i++) run(1);
        chk(name, busy, 0);
    endtask

    // EN dropped mid-conversion: no SCAN_DONE even if it was the last channel
    task automatic drop_en();
        en = 1'b0;
        if (next_bit(scan_mask, last_idx + 1) < 0) done_adj++;
        en_drops++;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
    endtask

    // ADC responder, reference model and result monitor for the main DUT
    initial begin
        int seen_drops = 0, cnt = 0, hold = 0, nb;
        bit pend = 0, in_scan = 0, prev_terr = 0;
        logic [11:0] pdata = '0;
        res_t r;
        ifa.adc_valid = 1'b0;
        ifa.adc_data  = '0;
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                ifa.adc_valid = 1'b0;
                pend = 0; hold = 0; prev_terr = 0;
            end else begin
                if (ifa.res_valid) begin
                    n_res++;
                    if (sbq.size() == 0) chk("unexpected_res", 1, 0);
                    else begin
                        r = sbq.pop_front();
                        chk("res_ch", ifa.res_ch, r.ch);
                        chk("res_data", ifa.res_data, r.data);
                    end
                end
                if (ifa.scan_done) n_done++;
                if (timeout_err && !prev_terr) chk("tmo_latency", cyc - silent_sync_cyc, 1024);
                prev_terr = timeout_err;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin ifa.adc_valid = 1'b0; ifa.adc_data = ~pdata; end
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        ifa.adc_valid = 1'b1;
                        ifa.adc_data  = pdata;
                        hold = 1 + $urandom_range(0, 2);
                        pend = 0;
                        sbq.push_back('{last_idx, int'(pdata)});
                    end else cnt--;
                end
                if (ifa.sync_tr) begin
                    n_sync++;
                    if (seen_drops != en_drops) begin in_scan = 0; seen_drops = en_drops; end
                    nb = in_scan ? next_bit(scan_mask, last_idx + 1) : -1;
                    if (nb < 0) begin scan_mask = ch_mask; nb = next_bit(scan_mask, 0); end
                    in_scan  = 1;
                    last_idx = nb;
                    chk("sync_adc_ch", ifa.adc_ch, 1 + nb);
                    if (next_bit(scan_mask, nb + 1) < 0) exp_done_iss++;
                    if (silent2 && nb == 2) silent_sync_cyc = cyc;
                    else begin
                        pend  = 1;
                        cnt   = lat;
                        pdata = rand_data ? 12'($urandom) : 12'(32'h100 + 1 + nb);
                    end
                end
            end
        end
    end

    // Second DUT: SCAN_PERIOD=500, single channel, ADC latency 20
    initial begin
        int ns = 0, t = 0, tprev = 0, pc = 0;
        reset_b_n = 1'b0; en_b = 1'b0; mask_b = '0; err_clr_b = 1'b0;
        ifb.adc_valid = 1'b0; ifb.adc_data = '0;
        repeat (3) @(negedge sys_clk);
        reset_b_n = 1'b1; mask_b = 8'h01; en_b = 1'b1;
        while (ns < 5 && t < 4000) begin
            @(negedge sys_clk);
            t++;
            if (ifb.adc_valid) ifb.adc_valid = 1'b0;
            if (pc > 0) begin
                pc--;
                if (pc == 0) begin ifb.adc_valid = 1'b1; ifb.adc_data = 12'h101; end
            end
            if (ifb.res_valid) chk("b_res_data", ifb.res_data, 12'h101);
            if (ifb.sync_tr) begin
                chk("b_sync_ch", ifb.adc_ch, 1);
                if (ns > 0) chk("b_period", t - tprev, 500);
                tprev = t;
                ns++;
                pc = 20;
            end
        end
        chk("b_sync_count", ns, 5);
        chk("b_no_timeout", terr_b, 0);
        b_done = 1;
    end

    initial begin
        int n0, old_sc, tgt;
        reset_n = 1'b0; en = 1'b0; ch_mask = '0; err_clr = 1'b0;
        run(3);
        chk("rst_adc_ch", ifa.adc_ch, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sync", ifa.sync_tr, 0);
        chk("rst_res_valid", ifa.res_valid, 0);
        chk("rst_scan_done", ifa.scan_done, 0);
        chk("rst_terr", timeout_err, 0);
        reset_n = 1'b1;
        run(5);

        // two full scans of 8'hA5
        ch_mask = 8'hA5; en = 1'b1;
        wait_done_cnt(2, 600, "a5_two_scans");
        chk("a5_sync_count", n_sync, 8);
        chk("a5_res_count", n_res, 8);
        chk("a5_done_model", n_done, exp_done_iss - done_adj);

        // EN dropped while waiting on idx 2
        wait_sync(2, 200, "drop_sync_idx2");
        run(5);
        drop_en();
        wait_idle(100, "drop_busy_low");
        n0 = n_sync;
        run(100);
        chk("drop_no_sync", n_sync - n0, 0);
        chk("drop_res_count", n_res, 10);
        chk("drop_no_done", n_done, 2);

        // idx 2 silent: timeout, scan resumes at idx 5
        silent2 = 1; en = 1'b1;
        for (int i = 0; i < 1500 && !timeout_err; i++) run(1);
        chk("tmo_set", timeout_err, 1);
        wait_done_cnt(3, 300, "tmo_scan_done");
        chk("tmo_res_count", n_res, 13);
        chk("tmo_sticky", timeout_err, 1);
        old_sc = silent_sync_cyc;
        pulse_clr();
        chk("tmo_cleared", timeout_err, 0);

        // err_clr coincident with a new timeout: set wins
        for (int i = 0; i < 300 && silent_sync_cyc == old_sc; i++) run(1);
        chk("tmo2_silent_sync", silent_sync_cyc != old_sc, 1);
        tgt = silent_sync_cyc + 1023;
        for (int i = 0; i < 1100 && cyc < tgt; i++) run(1);
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
        chk("tmo_set_wins", timeout_err, 1);
        silent2 = 0;
        wait_done_cnt(4, 300, "tmo2_scan_done");
        chk("tmo2_res_count", n_res, 16);
        pulse_clr();
        chk("tmo2_cleared", timeout_err, 0);

        // empty mask: no activity; then mask change mid-scan
        wait_sync(-1, 100, "m0_pre_sync");
        run(2);
        drop_en();
        wait_idle(100, "m0_idle");
        ch_mask = '0; en = 1'b1;
        n0 = n_sync;
        run(2000);
        chk("m0_no_sync", n_sync - n0, 0);
        chk("m0_busy", busy, 0);
        ch_mask = 8'h0F;
        wait_sync(1, 200, "m0f_idx1");
        run(1);
        ch_mask = 8'h80;
        n0 = n_done;
        wait_done_cnt(n0 + 1, 200, "m0f_done");
        wait_sync(7, 100, "m80_used");
        wait_done_cnt(n0 + 2, 100, "m80_done");

        // random masks, latencies and data
        rand_data = 1;
        for (int k = 0; k < 10; k++) begin
            wait_sync(-1, 300, "rand_sync");
            run(1);
            ch_mask = 8'($urandom_range(1, 255));
            lat = $urandom_range(4, 40);
        end
        wait_sync(-1, 300, "rand_last_sync");
        run(1);
        drop_en();
        wait_idle(200, "rand_idle");
        run(10);
        chk("rand_done_model", n_done, exp_done_iss - done_adj);
        chk("rand_sb_drained", sbq.size(), 0);

        // reset mid-WAIT
        rand_data = 0; lat = 20; ch_mask = 8'hA5; en = 1'b1;
        wait_sync(0, 100, "rst2_sync");
        run(5);
        drop_en();
        reset_n = 1'b0;
        #1;
        chk("rst2_adc_ch", ifa.adc_ch, 1);
        chk("rst2_busy", busy, 0);
        chk("rst2_res_valid", ifa.res_valid, 0);
        chk("rst2_sync", ifa.sync_tr, 0);
        run(3);
        reset_n = 1'b1;
        n0 = n_sync;
        run(50);
        chk("rst2_no_sync", n_sync - n0, 0);
        chk("rst2_idle", busy, 0);

        for (int i = 0; i < 4000 && !b_done; i++) run(1);
        chk("b_finished", b_done, 1);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
